// File: rtl/aes_spi_host.sv
// SPI mode-0 master: ships one AES frame (plaintext, {nk,nr}, key) to the encryption slave,
// waits out the compute interval, then reads the 16 ciphertext bytes back into a 128-bit word.
module aes_spi_host #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned WAIT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  input  logic [3:0]   nk,
  input  logic [3:0]   nr,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic         cs,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StGap,
    StWait,
    StRead,
    StDone
  } state_e;

  localparam logic [7:0]  HalfLast = 8'(CLK_DIV - 1);
  localparam logic [15:0] GapLast  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] WaitLast = 16'(WAIT_CYCLES - 1);

  state_e         state_q;
  logic           rd_phase_q;
  logic [5:0]     byte_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     half_cnt_q;
  logic [15:0]    idle_cnt_q;
  logic [127:0]   pt_q;
  logic [255:0]   key_q;
  logic [3:0]     nk_q;
  logic [3:0]     nr_q;
  logic [7:0]     tx_q;
  logic [127:0]   rx_q;

  logic [5:0]     wr_total;
  logic           nk_ok;
  logic           half_end;
  logic           bit_end;
  logic           byte_end;
  logic [7:0]     next_byte;

  always_comb begin
    wr_total  = 6'd17 + {nk_q, 2'b00};
    nk_ok     = (nk == 4'd4) || (nk == 4'd6) || (nk == 4'd8);
    half_end  = (half_cnt_q == HalfLast);
    bit_end   = ((state_q == StShift) || (state_q == StRead)) && half_end && sclk &&
                (bit_cnt_q == 3'd0);
    // With no gap configured the byte ends on the last sclk fall itself.
    byte_end  = (bit_end && (GAP_CYCLES == 0)) ||
                ((state_q == StGap) && (idle_cnt_q == GapLast));
    if (rd_phase_q) begin
      next_byte = 8'h00;
    end else if (byte_cnt_q < 6'd16) begin
      next_byte = pt_q[127:120];
    end else if (byte_cnt_q == 6'd16) begin
      next_byte = {nk_q, nr_q};
    end else begin
      next_byte = key_q[255:248];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_phase_q <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      idle_cnt_q <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      nk_q       <= '0;
      nr_q       <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      result     <= '0;
      cs         <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (nk_ok) begin
              busy       <= 1'b1;
              pt_q       <= plaintext;
              key_q      <= key;
              nk_q       <= nk;
              nr_q       <= nr;
              rd_phase_q <= 1'b0;
              byte_cnt_q <= '0;
              state_q    <= StLoad;
            end else begin
              error <= 1'b1;
            end
          end
        end
        StLoad: begin
          cs         <= 1'b0;
          sclk       <= 1'b0;
          mosi       <= next_byte[7];
          tx_q       <= next_byte;
          bit_cnt_q  <= 3'd7;
          half_cnt_q <= '0;
          byte_cnt_q <= byte_cnt_q + 6'd1;
          if (!rd_phase_q) begin
            if (byte_cnt_q < 6'd16) begin
              pt_q <= {pt_q[119:0], 8'h00};
            end else if (byte_cnt_q > 6'd16) begin
              key_q <= {key_q[247:0], 8'h00};
            end
          end
          state_q <= rd_phase_q ? StRead : StShift;
        end
        StShift, StRead: begin
          if (!half_end) begin
            half_cnt_q <= half_cnt_q + 8'd1;
          end else begin
            half_cnt_q <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (state_q == StRead) begin
                rx_q <= {rx_q[126:0], miso};
              end
            end else begin
              sclk <= 1'b0;
              if (bit_cnt_q == 3'd0) begin
                mosi       <= 1'b0;
                idle_cnt_q <= '0;
                state_q    <= StGap;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
                mosi      <= tx_q[6];
                tx_q      <= {tx_q[6:0], 1'b0};
              end
            end
          end
        end
        StGap: begin
          idle_cnt_q <= idle_cnt_q + 16'd1;
        end
        StWait: begin
          if (idle_cnt_q == WaitLast) begin
            state_q <= StLoad;
          end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
        end
        StDone: begin
          cs      <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          result  <= rx_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // End-of-byte routing overrides whatever the case arm chose.
      if (byte_end) begin
        idle_cnt_q <= '0;
        if (!rd_phase_q && (byte_cnt_q == wr_total)) begin
          rd_phase_q <= 1'b1;
          byte_cnt_q <= '0;
          state_q    <= (WAIT_CYCLES == 0) ? StLoad : StWait;
        end else if (rd_phase_q && (byte_cnt_q == 6'd16)) begin
          state_q <= StDone;
        end else begin
          state_q <= StLoad;
        end
      end
    end
  end

endmodule
